// File: rtl/param_fifo_if.sv
// FIFO access bundle: write/read requests, data and status flags.
// Handshake: wr_fifo/rd_fifo are requests sampled at the rising edge; a request
// is taken only when the FIFO can serve it, otherwise overflow/underflow pulses next cycle.
interface param_fifo_if #(
    parameter int fbits = 8,
    parameter int abits = 4
);
    logic             wr_fifo;
    logic             rd_fifo;
    logic [fbits-1:0] data_in;
    logic [fbits-1:0] data_out;
    logic             full;
    logic             empty;
    logic             afull;
    logic             aempty;
    logic [abits:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_fifo, rd_fifo, data_in,
        input  data_out, full, empty, afull, aempty, count, overflow, underflow
    );

    modport slave (
        input  wr_fifo, rd_fifo, data_in,
        output data_out, full, empty, afull, aempty, count, overflow, underflow
    );
endinterface

// File: rtl/param_fifo.sv
// Synchronous FIFO with registered read data, registered level flags and
// one-cycle overflow/underflow pulses for rejected requests.
module param_fifo #(
    parameter int fbits      = 8,
    parameter int abits      = 4,
    parameter int afull_lvl  = 2**abits - 2,
    parameter int aempty_lvl = 2
) (
    input logic        clk,
    input logic        clr_fifo,
    param_fifo_if.slave bus
);
    localparam int             depth      = 2**abits;
    localparam logic [abits:0] full_cnt   = (abits+1)'(depth);
    localparam logic [abits:0] afull_cnt  = (abits+1)'(afull_lvl);
    localparam logic [abits:0] aempty_cnt = (abits+1)'(aempty_lvl);

    logic [fbits-1:0] mem [depth];
    logic [abits-1:0] wptr;
    logic [abits-1:0] rptr;
    logic [abits:0]   count_q;
    logic [abits:0]   count_nxt;
    logic [fbits-1:0] data_q;
    logic             full_q;
    logic             empty_q;
    logic             afull_q;
    logic             aempty_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             rd_ok;
    logic             wr_ok;

    // A read frees a slot on the same edge, so a full FIFO can still take a write.
    assign rd_ok = bus.rd_fifo && !empty_q;
    assign wr_ok = bus.wr_fifo && (!full_q || rd_ok);

    always_comb begin
        count_nxt = count_q;
        if (wr_ok && !rd_ok)
            count_nxt = count_q + 1'b1;
        else if (rd_ok && !wr_ok)
            count_nxt = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!clr_fifo && wr_ok)
            mem[wptr] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (clr_fifo) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            data_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok) begin
                data_q <= mem[rptr];
                rptr   <= rptr + 1'b1;
            end
            count_q     <= count_nxt;
            full_q      <= (count_nxt == full_cnt);
            empty_q     <= (count_nxt == '0);
            afull_q     <= (count_nxt >= afull_cnt);
            aempty_q    <= (count_nxt <= aempty_cnt);
            overflow_q  <= bus.wr_fifo && !wr_ok;
            underflow_q <= bus.rd_fifo && !rd_ok;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.afull     = afull_q;
    assign bus.aempty    = aempty_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo at default parameters (8-bit words, 16 deep).
module tb_param_fifo;
    logic clk = 1'b0;
    logic clr_fifo = 1'b1;
    int   checks = 0;
    int   errors = 0;

    param_fifo_if #(.fbits(8), .abits(4)) bus ();

    param_fifo #(.fbits(8), .abits(4)) dut (
        .clk      (clk),
        .clr_fifo (clr_fifo),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_fifo = 1'b0;
        bus.rd_fifo = 1'b0;
    endtask

    task automatic test_reset();
        clr_fifo = 1'b1;
        bus.wr_fifo = 1'b1;
        bus.rd_fifo = 1'b1;
        bus.data_in = 8'h3C;
        cycle();
        cycle();
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.aempty !== 1'b1 ||
            bus.full !== 1'b0 || bus.afull !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got count=%0d e=%b ae=%b f=%b af=%b exp 0 1 1 0 0",
                     bus.count, bus.empty, bus.aempty, bus.full, bus.afull);
        end
        checks++;
        if (bus.data_out !== 8'h00 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got dout=%h ovf=%b unf=%b exp 00 0 0",
                     bus.data_out, bus.overflow, bus.underflow);
        end
        idle();
        clr_fifo = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            bus.wr_fifo = 1'b1;
            bus.data_in = 8'(i);
            cycle();
            checks++;
            if (bus.count !== 5'(i+1) || bus.full !== (i == 15) || bus.afull !== (i >= 13) ||
                bus.empty !== 1'b0 || bus.aempty !== (i <= 1) || bus.overflow !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d got count=%0d f=%b af=%b e=%b ae=%b ovf=%b exp %0d %b %b 0 %b 0",
                         i, bus.count, bus.full, bus.afull, bus.empty, bus.aempty, bus.overflow,
                         i+1, (i == 15), (i >= 13), (i <= 1));
            end
        end
        bus.data_in = 8'hAA;
        cycle();
        checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 5'd16 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow got ovf=%b count=%0d full=%b exp 1 16 1",
                     bus.overflow, bus.count, bus.full);
        end
        idle();
        cycle();
        checks++;
        if (bus.overflow !== 1'b0 || bus.count !== 5'd16) begin
            errors++;
            $display("FAIL fill_overflow_pulse got ovf=%b count=%0d exp 0 16",
                     bus.overflow, bus.count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            bus.rd_fifo = 1'b1;
            cycle();
            checks++;
            if (bus.data_out !== 8'(i) || bus.count !== 5'(15-i) || bus.empty !== (i == 15) ||
                bus.full !== 1'b0 || bus.underflow !== 1'b0) begin
                errors++;
                $display("FAIL drain_%0d got dout=%h count=%0d e=%b f=%b unf=%b exp %h %0d %b 0 0",
                         i, bus.data_out, bus.count, bus.empty, bus.full, bus.underflow,
                         8'(i), 15-i, (i == 15));
            end
        end
        cycle();
        checks++;
        if (bus.underflow !== 1'b1 || bus.data_out !== 8'h0F || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL drain_underflow got unf=%b dout=%h count=%0d exp 1 0f 0",
                     bus.underflow, bus.data_out, bus.count);
        end
        idle();
        cycle();
        checks++;
        if (bus.underflow !== 1'b0 || bus.data_out !== 8'h0F) begin
            errors++;
            $display("FAIL drain_underflow_pulse got unf=%b dout=%h exp 0 0f",
                     bus.underflow, bus.data_out);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] exp;
        int         k = 0;
        for (int i = 0; i < 2; i++) begin
            bus.wr_fifo = 1'b1;
            bus.data_in = 8'(8'h10 + k);
            exp_q.push_back(bus.data_in);
            k++;
            cycle();
        end
        // 38 paired cycles plus the 2 priming writes walk both pointers past index 15 twice.
        for (int i = 0; i < 38; i++) begin
            bus.wr_fifo = 1'b1;
            bus.rd_fifo = 1'b1;
            bus.data_in = 8'(8'h10 + k);
            k++;
            exp = exp_q.pop_front();
            exp_q.push_back(bus.data_in);
            cycle();
            checks++;
            if (bus.data_out !== exp || bus.count !== 5'd2) begin
                errors++;
                $display("FAIL wrap_%0d got dout=%h count=%0d exp %h 2",
                         i, bus.data_out, bus.count, exp);
            end
        end
        bus.wr_fifo = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.rd_fifo = 1'b1;
            exp = exp_q.pop_front();
            cycle();
            checks++;
            if (bus.data_out !== exp || bus.count !== 5'(1-i)) begin
                errors++;
                $display("FAIL wrap_tail_%0d got dout=%h count=%0d exp %h %0d",
                         i, bus.data_out, bus.count, exp, 1-i);
            end
        end
        idle();
    endtask

    task automatic test_simultaneous();
        bus.wr_fifo = 1'b1;
        bus.rd_fifo = 1'b1;
        bus.data_in = 8'h55;
        cycle();
        checks++;
        if (bus.count !== 5'd1 || bus.underflow !== 1'b1 || bus.empty !== 1'b0 ||
            bus.data_out !== 8'h37) begin
            errors++;
            $display("FAIL simul_empty got count=%0d unf=%b e=%b dout=%h exp 1 1 0 37",
                     bus.count, bus.underflow, bus.empty, bus.data_out);
        end
        bus.rd_fifo = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.data_in = 8'(8'h60 + i);
            cycle();
        end
        checks++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_fill got count=%0d full=%b unf=%b exp 16 1 0",
                     bus.count, bus.full, bus.underflow);
        end
        bus.rd_fifo = 1'b1;
        bus.data_in = 8'h77;
        cycle();
        checks++;
        if (bus.count !== 5'd16 || bus.data_out !== 8'h55 || bus.overflow !== 1'b0 ||
            bus.full !== 1'b1) begin
            errors++;
            $display("FAIL simul_full got count=%0d dout=%h ovf=%b full=%b exp 16 55 0 1",
                     bus.count, bus.data_out, bus.overflow, bus.full);
        end
        bus.wr_fifo = 1'b0;
        for (int i = 0; i < 9; i++)
            cycle();
        checks++;
        if (bus.count !== 5'd7 || bus.data_out !== 8'h68 || bus.afull !== 1'b0) begin
            errors++;
            $display("FAIL simul_partial_drain got count=%0d dout=%h af=%b exp 7 68 0",
                     bus.count, bus.data_out, bus.afull);
        end
        idle();
    endtask

    task automatic test_clear();
        clr_fifo = 1'b1;
        bus.wr_fifo = 1'b1;
        bus.data_in = 8'h99;
        cycle();
        clr_fifo = 1'b0;
        idle();
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.data_out !== 8'h00 ||
            bus.aempty !== 1'b1) begin
            errors++;
            $display("FAIL clear_state got count=%0d e=%b dout=%h ae=%b exp 0 1 00 1",
                     bus.count, bus.empty, bus.data_out, bus.aempty);
        end
        bus.rd_fifo = 1'b1;
        cycle();
        checks++;
        if (bus.underflow !== 1'b1 || bus.data_out !== 8'h00 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL clear_read got unf=%b dout=%h count=%0d exp 1 00 0",
                     bus.underflow, bus.data_out, bus.count);
        end
        bus.rd_fifo = 1'b0;
        bus.wr_fifo = 1'b1;
        bus.data_in = 8'hC3;
        cycle();
        bus.wr_fifo = 1'b0;
        bus.rd_fifo = 1'b1;
        cycle();
        checks++;
        if (bus.data_out !== 8'hC3 || bus.count !== 5'd0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_fresh_word got dout=%h count=%0d e=%b exp c3 0 1",
                     bus.data_out, bus.count, bus.empty);
        end
        idle();
    endtask

    initial begin
        bus.wr_fifo = 1'b0;
        bus.rd_fifo = 1'b0;
        bus.data_in = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        bus.data_in = 8'h37;
        test_wrap();
        test_simultaneous();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
